// File: rtl/blake_round_ctrl_if.sv
// Host <-> BLAKE round controller signal bundle.
// master = host side (drives start/abort), slave = controller side.
interface blake_round_ctrl_if #(
  parameter int RW = 4
);
  logic          start;
  logic          abort;
  logic          ready;
  logic          busy;
  logic          init_round;
  logic [RW-1:0] round_idx;
  logic          ctrl_finalize;
  logic          done;
  logic [RW+2:0] round_cnt_dbg;

  modport master (
    output start, abort,
    input  ready, busy, init_round, round_idx, ctrl_finalize, done, round_cnt_dbg
  );

  modport slave (
    input  start, abort,
    output ready, busy, init_round, round_idx, ctrl_finalize, done, round_cnt_dbg
  );
endinterface

// File: rtl/blake_round_ctrl.sv
// Sequences one BLAKE-512 block: init strobe, NROUNDS round indices, finalize, done.
// Latency start->done = NROUNDS*CYC_PER_ROUND+2; start is ignored unless ready (no queuing).
module blake_round_ctrl #(
  parameter int NROUNDS       = 16,
  parameter int CYC_PER_ROUND = 1,
  parameter int RW            = 4
) (
  input  logic               clk,
  input  logic               rstb,
  blake_round_ctrl_if.slave  bus
);

  localparam int SW = (CYC_PER_ROUND > 1) ? $clog2(CYC_PER_ROUND) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(NROUNDS - 1);
  localparam logic [SW-1:0] LAST_S = SW'(CYC_PER_ROUND - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] round_idx, round_idx_nxt;
  logic [SW-1:0] sub_cnt, sub_cnt_nxt;
  logic [RW+2:0] round_cnt, round_cnt_nxt;
  logic          accept;

  // abort in IDLE masks start so the datapath never captures a cancelled block
  assign accept = (state == IDLE) & bus.start & ~bus.abort;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      round_idx <= '0;
      sub_cnt   <= '0;
      round_cnt <= '0;
    end else begin
      state     <= state_nxt;
      round_idx <= round_idx_nxt;
      sub_cnt   <= sub_cnt_nxt;
      round_cnt <= round_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    round_idx_nxt = round_idx;
    sub_cnt_nxt   = sub_cnt;
    round_cnt_nxt = round_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt     = ROUND;
          round_idx_nxt = '0;
          sub_cnt_nxt   = '0;
          round_cnt_nxt = '0;
        end
      end
      ROUND: begin
        round_cnt_nxt = round_cnt + 1'b1;
        if (bus.abort) begin
          state_nxt     = IDLE;
          round_idx_nxt = '0;
          sub_cnt_nxt   = '0;
        end else if (sub_cnt == LAST_S) begin
          sub_cnt_nxt = '0;
          if (round_idx == LAST_R) begin
            state_nxt     = FINAL;
            round_idx_nxt = '0;
          end else begin
            round_idx_nxt = round_idx + 1'b1;
          end
        end else begin
          sub_cnt_nxt = sub_cnt + 1'b1;
        end
      end
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: begin
        state_nxt     = IDLE;
        round_idx_nxt = '0;
        sub_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.ready         = (state == IDLE);
  assign bus.busy          = (state == ROUND) | (state == FINAL);
  assign bus.init_round    = accept;
  assign bus.round_idx     = round_idx;
  assign bus.ctrl_finalize = (state == FINAL);
  assign bus.done          = (state == DONE);
  assign bus.round_cnt_dbg = round_cnt;

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed checks of the round controller at default timing and at CYC_PER_ROUND=2.
module tb_blake_round_ctrl;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  blake_round_ctrl_if #(.RW(4)) h1 ();
  blake_round_ctrl_if #(.RW(4)) h2 ();

  blake_round_ctrl #(.NROUNDS(16), .CYC_PER_ROUND(1), .RW(4)) u_dut1 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (h1.slave)
  );

  blake_round_ctrl #(.NROUNDS(16), .CYC_PER_ROUND(2), .RW(4)) u_dut2 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (h2.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance to just after the next falling edge
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  int acc_n, viol, extra, lat;
  int acc_at[4];

  initial begin
    h1.start = 1'b0; h1.abort = 1'b0;
    h2.start = 1'b0; h2.abort = 1'b0;

    // reset state
    #12;
    check("rst_ready", h1.ready, 1);
    check("rst_busy", h1.busy, 0);
    check("rst_idx", h1.round_idx, 0);
    check("rst_fin", h1.ctrl_finalize, 0);
    check("rst_done", h1.done, 0);
    check("rst_cnt", h1.round_cnt_dbg, 0);
    cyc();
    rstb = 1'b1;
    cyc();

    // single block, default timing
    h1.start = 1'b1; #1;
    check("t1_init", h1.init_round, 1);
    cyc(); h1.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check("t1_idx", h1.round_idx, c - 1);
      check("t1_busy", h1.busy, 1);
      cyc();
    end
    check("t1_fin", h1.ctrl_finalize, 1);
    check("t1_fin_done", h1.done, 0);
    check("t1_cnt", h1.round_cnt_dbg, 16);
    check("t1_fin_idx", h1.round_idx, 0);
    cyc();
    h1.start = 1'b1; #1;
    check("t1_done", h1.done, 1);
    check("t1_done_fin", h1.ctrl_finalize, 0);
    check("t1_done_ready", h1.ready, 0);
    check("t1_done_init", h1.init_round, 0);
    h1.start = 1'b0;
    cyc();
    check("t1_idle_ready", h1.ready, 1);
    check("t1_idle_done", h1.done, 0);

    // start held high: accepts at 0, 19, 38
    acc_n = 0; viol = 0;
    h1.start = 1'b1;
    for (int k = 0; k <= 56; k++) begin
      #1;
      if (h1.init_round) begin
        if (acc_n < 4) acc_at[acc_n] = k;
        acc_n++;
        if (!h1.ready) viol++;
      end
      if (32'(h1.init_round) + 32'(h1.ctrl_finalize) + 32'(h1.done) > 1) viol++;
      cyc();
    end
    h1.start = 1'b0;
    check("t2_count", acc_n, 3);
    check("t2_acc0", acc_at[0], 0);
    check("t2_acc1", acc_at[1], 19);
    check("t2_acc2", acc_at[2], 38);
    check("t2_viol", viol, 0);

    // abort at round 7
    h1.start = 1'b1; #1;
    cyc(); h1.start = 1'b0;
    for (int c = 1; c < 8; c++) cyc();
    check("t3_idx7", h1.round_idx, 7);
    h1.abort = 1'b1;
    cyc(); h1.abort = 1'b0;
    check("t3_ready", h1.ready, 1);
    check("t3_busy", h1.busy, 0);
    check("t3_idx", h1.round_idx, 0);
    check("t3_cnt", h1.round_cnt_dbg, 8);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (h1.ctrl_finalize || h1.done) extra++;
      cyc();
    end
    check("t3_no_fin", extra, 0);
    h1.start = 1'b1; #1;
    cyc(); h1.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 30 && lat == 0; n++) begin
      if (h1.done) lat = n;
      else cyc();
    end
    check("t3_restart_lat", lat, 18);
    cyc();

    // CYC_PER_ROUND = 2
    h2.start = 1'b1; #1;
    check("t4_init", h2.init_round, 1);
    cyc(); h2.start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check("t4_idx", h2.round_idx, (c - 1) / 2);
      cyc();
    end
    check("t4_fin", h2.ctrl_finalize, 1);
    check("t4_cnt", h2.round_cnt_dbg, 32);
    cyc();
    check("t4_done", h2.done, 1);
    cyc();
    check("t4_ready", h2.ready, 1);

    // reset mid-round
    h1.start = 1'b1; #1;
    cyc(); h1.start = 1'b0;
    for (int c = 1; c < 11; c++) cyc();
    check("t5_idx10", h1.round_idx, 10);
    rstb = 1'b0; #1;
    check("t5_ready", h1.ready, 1);
    check("t5_busy", h1.busy, 0);
    check("t5_idx", h1.round_idx, 0);
    check("t5_done", h1.done, 0);
    cyc(); rstb = 1'b1;
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      if (h1.ctrl_finalize || h1.done || !h1.ready) extra++;
      cyc();
    end
    check("t5_quiet", extra, 0);

    // start with abort in IDLE
    h1.start = 1'b1; h1.abort = 1'b1; #1;
    check("t6_init", h1.init_round, 0);
    cyc();
    check("t6_ready", h1.ready, 1);
    check("t6_busy", h1.busy, 0);
    h1.start = 1'b0; h1.abort = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
